// File: rtl/myproject_mul_share_pkg.sv
// Shared defaults for the shared-multiplier arbiter: widths, requester count,
// round-robin pointer width and the pointer-advance helper.
package myproject_mul_share_pkg;

    localparam int NREQ_DEF   = 4;
    localparam int DIN0_W_DEF = 16;
    localparam int DIN1_W_DEF = 6;
    localparam int DOUT_W_DEF = DIN0_W_DEF + DIN1_W_DEF;
    localparam int RR_W       = (NREQ_DEF > 1) ? $clog2(NREQ_DEF) : 1;
    localparam int OPCNT_W    = 16;

    // Next round-robin start point: one past the winner, wrapping at nreq.
    function automatic logic [RR_W-1:0] rr_next(input logic [RR_W-1:0] idx, input int nreq);
        logic [RR_W-1:0] nxt;
        if (int'(idx) >= nreq - 1) begin
            nxt = {RR_W{1'b0}};
        end else begin
            nxt = idx + {{(RR_W-1){1'b0}}, 1'b1};
        end
        return nxt;
    endfunction

endpackage

// File: rtl/myproject_mul_share_arb_if.sv
// Requester and result bundle of the shared-multiplier arbiter.
interface myproject_mul_share_arb_if
    import myproject_mul_share_pkg::*;
#(
    parameter int NREQ   = NREQ_DEF,
    parameter int DIN0_W = DIN0_W_DEF,
    parameter int DIN1_W = DIN1_W_DEF,
    parameter int DOUT_W = DOUT_W_DEF
);
    logic [NREQ-1:0]        req_valid;
    logic [NREQ-1:0]        req_ready;
    logic [NREQ*DIN0_W-1:0] req_a;
    logic [NREQ*DIN1_W-1:0] req_b;
    logic [NREQ-1:0]        res_valid;
    logic [DOUT_W-1:0]      res_data;
    logic                   busy;
    logic [OPCNT_W-1:0]     op_count;

    modport master (
        output req_valid, req_a, req_b,
        input  req_ready, res_valid, res_data, busy, op_count
    );

    modport slave (
        input  req_valid, req_a, req_b,
        output req_ready, res_valid, res_data, busy, op_count
    );
endinterface

// File: rtl/myproject_mul_share_core.sv
// Registered signed x unsigned multiplier; its output register is pipeline stage 2.
module myproject_mul_share_core #(
    parameter int DIN0_W = 16,
    parameter int DIN1_W = 6,
    parameter int DOUT_W = 22
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     ce,
    input  logic                     ld,
    input  logic signed [DIN0_W-1:0] a,
    input  logic        [DIN1_W-1:0] b,
    output logic        [DOUT_W-1:0] p
);
    logic signed [DOUT_W-1:0] a_ext_s;
    logic signed [DOUT_W-1:0] b_ext_s;
    logic        [DOUT_W-1:0] p_r;

    // B is zero-extended so it is always non-negative; the product fits DOUT_W exactly.
    assign a_ext_s = {{(DOUT_W-DIN0_W){a[DIN0_W-1]}}, a};
    assign b_ext_s = {{(DOUT_W-DIN1_W){1'b0}}, b};

    // Product register, loaded only when stage 1 holds a valid operation.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            p_r <= {DOUT_W{1'b0}};
        end else if (ce && ld) begin
            p_r <= a_ext_s * b_ext_s;
        end else begin
            p_r <= p_r;
        end
    end

    assign p = p_r;
endmodule

// File: rtl/myproject_mul_share_arb.sv
// Round-robin arbiter sharing one two-stage multiplier among NREQ requesters.
// Arbitration, the one-hot tag pipeline, busy and the op counter live here.
module myproject_mul_share_arb
    import myproject_mul_share_pkg::*;
#(
    parameter int NREQ   = NREQ_DEF,
    parameter int DIN0_W = DIN0_W_DEF,
    parameter int DIN1_W = DIN1_W_DEF,
    parameter int DOUT_W = DOUT_W_DEF
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        ce,
    myproject_mul_share_arb_if.slave    bus
);
    logic [RR_W-1:0]          rr_ptr_r;
    logic [NREQ-1:0]          grant_s;
    logic [RR_W-1:0]          win_idx_s;
    logic                     found_s;
    int                       idx_s;
    logic                     xfer_s;
    logic signed [DIN0_W-1:0] sel_a_s;
    logic        [DIN1_W-1:0] sel_b_s;

    logic                     s1_valid_r;
    logic [NREQ-1:0]          s1_tag_r;
    logic signed [DIN0_W-1:0] s1_a_r;
    logic        [DIN1_W-1:0] s1_b_r;
    logic [NREQ-1:0]          s2_tag_r;
    logic                     busy_r;
    logic [OPCNT_W-1:0]       op_count_r;
    logic [DOUT_W-1:0]        prod_s;

    // Round-robin grant: first valid requester at or after rr_ptr, wrapping; none while stalled or in reset.
    always_comb begin
        grant_s   = {NREQ{1'b0}};
        win_idx_s = {RR_W{1'b0}};
        found_s   = 1'b0;
        idx_s     = 0;
        if (ce && reset_n) begin
            for (int k = 0; k < NREQ; k++) begin
                idx_s = int'(rr_ptr_r) + k;
                if (idx_s >= NREQ) begin
                    idx_s = idx_s - NREQ;
                end else begin
                    idx_s = idx_s;
                end
                if (!found_s && bus.req_valid[idx_s]) begin
                    found_s        = 1'b1;
                    grant_s[idx_s] = 1'b1;
                    win_idx_s      = idx_s[RR_W-1:0];
                end else begin
                    found_s = found_s;
                end
            end
        end else begin
            grant_s = {NREQ{1'b0}};
        end
    end

    assign xfer_s = |grant_s;

    // Operand mux for the winning requester.
    always_comb begin
        sel_a_s = bus.req_a[int'(win_idx_s)*DIN0_W +: DIN0_W];
        sel_b_s = bus.req_b[int'(win_idx_s)*DIN1_W +: DIN1_W];
    end

    // Round-robin pointer and accepted-op counter advance only on a transfer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr_r   <= {RR_W{1'b0}};
            op_count_r <= {OPCNT_W{1'b0}};
        end else if (xfer_s) begin
            rr_ptr_r   <= rr_next(win_idx_s, NREQ);
            op_count_r <= op_count_r + {{(OPCNT_W-1){1'b0}}, 1'b1};
        end else begin
            rr_ptr_r   <= rr_ptr_r;
            op_count_r <= op_count_r;
        end
    end

    // Stage 1: capture operands and the one-hot owner tag of the accepted request.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_r <= 1'b0;
            s1_tag_r   <= {NREQ{1'b0}};
            s1_a_r     <= {DIN0_W{1'b0}};
            s1_b_r     <= {DIN1_W{1'b0}};
        end else if (ce) begin
            s1_valid_r <= xfer_s;
            s1_tag_r   <= grant_s;
            if (xfer_s) begin
                s1_a_r <= sel_a_s;
                s1_b_r <= sel_b_s;
            end else begin
                s1_a_r <= s1_a_r;
                s1_b_r <= s1_b_r;
            end
        end else begin
            s1_valid_r <= s1_valid_r;
            s1_tag_r   <= s1_tag_r;
            s1_a_r     <= s1_a_r;
            s1_b_r     <= s1_b_r;
        end
    end

    // Stage 2 tag follows the product; busy reflects what stages 1 and 2 will hold.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s2_tag_r <= {NREQ{1'b0}};
            busy_r   <= 1'b0;
        end else if (ce) begin
            s2_tag_r <= s1_valid_r ? s1_tag_r : {NREQ{1'b0}};
            busy_r   <= xfer_s | s1_valid_r;
        end else begin
            s2_tag_r <= s2_tag_r;
            busy_r   <= busy_r;
        end
    end

    myproject_mul_share_core #(
        .DIN0_W (DIN0_W),
        .DIN1_W (DIN1_W),
        .DOUT_W (DOUT_W)
    ) u_core (
        .clk     (clk),
        .reset_n (reset_n),
        .ce      (ce),
        .ld      (s1_valid_r),
        .a       (s1_a_r),
        .b       (s1_b_r),
        .p       (prod_s)
    );

    assign bus.req_ready = grant_s;
    assign bus.res_valid = s2_tag_r;
    assign bus.res_data  = prod_s;
    assign bus.busy      = busy_r;
    assign bus.op_count  = op_count_r;
endmodule

// File: tb/tb_myproject_mul_share_arb.sv
// Scoreboard bench for myproject_mul_share_arb: directed vectors push the
// expected owner/product; a negedge monitor pops and compares each result.
module tb_myproject_mul_share_arb;

    typedef struct {
        logic [3:0]  tag;
        logic [21:0] data;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic ce = 1'b1;
    logic ce_q = 1'b0;
    int   cyc_en = 0;
    int   total = 0;
    int   bad = 0;
    exp_t sb[$];
    exp_t mon_e;

    myproject_mul_share_arb_if bus ();

    myproject_mul_share_arb dut (
        .clk     (clk),
        .reset_n (reset_n),
        .ce      (ce),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Track whether the last edge was enabled and count enabled edges.
    always @(posedge clk) begin
        ce_q <= ce;
        if (ce) cyc_en <= cyc_en + 1;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Result monitor: compares each result with the oldest expectation.
    always @(negedge clk) begin
        if (reset_n && ce_q) begin
            if (bus.res_valid != 4'd0) begin
                if (sb.size() == 0) begin
                    chk("res_unexpected", 32'(bus.res_valid), 32'd0);
                end else begin
                    mon_e = sb.pop_front();
                    chk("res_tag", 32'(bus.res_valid), 32'(mon_e.tag));
                    chk("res_data", 32'(bus.res_data), 32'(mon_e.data));
                    chk("res_latency", 32'(cyc_en), 32'(mon_e.cyc));
                end
            end else if (sb.size() != 0 && sb[0].cyc <= cyc_en) begin
                mon_e = sb.pop_front();
                chk("res_missing", 32'(bus.res_valid), 32'(mon_e.tag));
            end
        end
    end

    task automatic set_op(input int i, input int a, input int b);
        bus.req_a[i*16 +: 16] = 16'(a);
        bus.req_b[i*6 +: 6]   = 6'(b);
    endtask

    // One enabled cycle: present req_valid, check the grant, expect the product.
    task automatic cycle(input logic [3:0] vld, input logic [3:0] gnt, input int prod);
        bus.req_valid = vld;
        @(negedge clk);
        chk("grant", 32'(bus.req_ready), 32'(gnt));
        if (gnt != 4'd0) sb.push_back('{tag: gnt, data: 22'(prod), cyc: cyc_en + 2});
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        bus.req_valid = 4'd0;
        sb.delete();
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req_valid = 4'hF;
        bus.req_a = '0;
        bus.req_b = '0;

        // Reset state, with every requester asking.
        @(negedge clk);
        chk("rst_ready", 32'(bus.req_ready), 32'd0);
        chk("rst_res_valid", 32'(bus.res_valid), 32'd0);
        chk("rst_res_data", 32'(bus.res_data), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_op_count", 32'(bus.op_count), 32'd0);
        bus.req_valid = 4'd0;
        #1 reset_n = 1'b1;
        @(posedge clk); #1;

        // Requester 2 streaming two ops back to back.
        set_op(2, 100, 3);
        cycle(4'b0100, 4'b0100, 300);
        set_op(2, -5, 7);
        cycle(4'b0100, 4'b0100, -35);
        repeat (3) cycle(4'b0000, 4'b0000, 0);
        chk("t1_op_count", 32'(bus.op_count), 32'd2);

        // All four requesting from reset: grant order 0,1,2,3,0.
        do_reset();
        for (int i = 0; i < 4; i++) set_op(i, 10 * (i + 1), i + 1);
        cycle(4'hF, 4'b0001, 10);
        cycle(4'hF, 4'b0010, 40);
        cycle(4'hF, 4'b0100, 90);
        cycle(4'hF, 4'b1000, 160);
        cycle(4'hF, 4'b0001, 10);
        repeat (3) cycle(4'b0000, 4'b0000, 0);

        // Operand extremes on requester 1.
        set_op(1, -32768, 63);
        cycle(4'b0010, 4'b0010, -2064384);
        set_op(1, 32767, 63);
        cycle(4'b0010, 4'b0010, 2064321);
        set_op(1, -1, 0);
        cycle(4'b0010, 4'b0010, 0);
        repeat (3) cycle(4'b0000, 4'b0000, 0);

        // Freeze with two ops in flight.
        do_reset();
        set_op(0, 7, 5);
        cycle(4'b0001, 4'b0001, 35);
        set_op(1, -3, 2);
        cycle(4'b0010, 4'b0010, -6);
        ce = 1'b0;
        bus.req_valid = 4'hF;
        repeat (3) begin
            @(negedge clk);
            chk("frz_ready", 32'(bus.req_ready), 32'd0);
            chk("frz_res_valid", 32'(bus.res_valid), 32'h1);
            chk("frz_res_data", 32'(bus.res_data), 32'd35);
            chk("frz_busy", 32'(bus.busy), 32'd1);
            chk("frz_op_count", 32'(bus.op_count), 32'd2);
            @(posedge clk); #1;
        end
        ce = 1'b1;
        repeat (4) cycle(4'b0000, 4'b0000, 0);
        chk("frz_op_count_end", 32'(bus.op_count), 32'd2);
        chk("frz_busy_end", 32'(bus.busy), 32'd0);

        // Reset pulse with ops in flight.
        set_op(2, 1, 1);
        cycle(4'b0100, 4'b0100, 1);
        set_op(1, 2, 2);
        cycle(4'b0010, 4'b0010, 4);
        #2;
        reset_n = 1'b0;
        sb.delete();
        bus.req_valid = 4'hF;
        #1;
        chk("mid_rst_res_valid", 32'(bus.res_valid), 32'd0);
        chk("mid_rst_busy", 32'(bus.busy), 32'd0);
        chk("mid_rst_res_data", 32'(bus.res_data), 32'd0);
        chk("mid_rst_op_count", 32'(bus.op_count), 32'd0);
        chk("mid_rst_ready", 32'(bus.req_ready), 32'd0);
        bus.req_valid = 4'd0;
        @(negedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        set_op(0, 9, 9);
        cycle(4'hF, 4'b0001, 81);
        repeat (4) cycle(4'b0000, 4'b0000, 0);

        // Counter wrap: 65537 accepted ops.
        do_reset();
        set_op(0, 2, 3);
        repeat (65537) cycle(4'b0001, 4'b0001, 6);
        repeat (3) cycle(4'b0000, 4'b0000, 0);
        chk("wrap_op_count", 32'(bus.op_count), 32'd1);

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/myproject_mul_share_arb.md
MYPROJECT_MUL_SHARE_ARB -- requirements
Module: myproject_mul_share_arb

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of requesters sharing one multiplier.
REQ-002 SHALL have parameter DIN0_W, default 16, signed operand A width.
REQ-003 SHALL have parameter DIN1_W, default 6, unsigned operand B width.
REQ-004 SHALL have parameter DOUT_W, default 22, product width (DIN0_W+DIN1_W).
REQ-005 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-006 SHALL have port reset_n  in  1  asynchronous, active-low reset.
REQ-007 SHALL have port ce  in  1  global pipeline enable; 0 freezes all state.
REQ-008 SHALL have port req_valid  in  NREQ  per-requester operand-valid.
REQ-009 SHALL have port req_ready  out  NREQ  per-requester grant/accept, one-hot or zero.
REQ-010 SHALL have port req_a  in  NREQ*DIN0_W  packed signed operands, requester i at bits [i*DIN0_W +: DIN0_W].
REQ-011 SHALL have port req_b  in  NREQ*DIN1_W  packed unsigned operands, same packing.
REQ-012 SHALL have port res_valid  out  NREQ  one-hot result strobe naming the owning requester.
REQ-013 SHALL have port res_data  out  DOUT_W  signed product for the strobed requester.
REQ-014 SHALL have port busy  out  1  high while any accepted operation is in flight.
REQ-015 SHALL have port op_count  out  16  count of accepted operations, wraps modulo 2^16.

Function
REQ-016 SHALL accept one request per cycle at most: transfer on requester i when req_valid[i] & req_ready[i] on a clk edge.
REQ-017 SHALL grant combinationally by round-robin from pointer rr_ptr: lowest index >= rr_ptr (wrapping) with req_valid set.
REQ-018 SHALL drive req_ready all-zero when ce=0 or no req_valid is set.
REQ-019 SHALL advance rr_ptr to (winner+1) mod NREQ on each transfer; rr_ptr SHALL be unchanged otherwise.
REQ-020 SHALL register operands and one-hot tag in stage 1 on transfer; stage 2 SHALL register product and tag.
REQ-021 SHALL present res_valid/res_data exactly 2 ce-enabled cycles after transfer; throughput 1 op/cycle.
REQ-022 SHALL compute res_data = signed(A) * signed({1'b0,B}), exact, no truncation or saturation.
REQ-023 SHALL drive res_valid all-zero on bubbles; res_data on bubble cycles is don't-care.
REQ-024 SHALL, when ce=0, hold both pipeline stages, rr_ptr, op_count and outputs unchanged; resume on ce=1 with no loss or duplication.
REQ-025 SHALL assert busy when stage-1 or stage-2 valid is set.
REQ-026 SHALL increment op_count by 1 per transfer; 16'hFFFF+1 -> 0.
REQ-027 SHALL permit req_valid deassertion before grant without error; ungranted operands are not retained.
REQ-028 SHALL not apply backpressure on results; consumer always accepts res_valid.

Reset
REQ-029 SHALL, on reset_n low, immediately clear stage valids, res_valid=0, res_data=0, busy=0, rr_ptr=0, op_count=0.
REQ-030 SHALL discard in-flight operations on reset mid-operation; none emerge after reset_n rises.
REQ-031 SHALL drive req_ready all-zero while reset_n is low.

Structure
REQ-032 SHALL place default widths, NREQ and the round-robin pointer width (clog2(NREQ)) in shared package myproject_mul_share_pkg.
REQ-033 SHALL instantiate one sub-module myproject_mul_share_core: registered signed x unsigned multiplier with ce, holding stage 2.
REQ-034 SHALL keep arbitration, tag pipeline and counters in the top module.

Verification
REQ-035 SHALL test single requester 2 streaming A=100,B=3 then A=-5,B=7 back-to-back -> res_valid=4'b0100 with 300 at T+2, -35 at T+3.
REQ-036 SHALL test all four requesting continuously from reset -> grant order 0,1,2,3,0; res_valid order identical, 2 cycles later.
REQ-037 SHALL test extremes A=-32768,B=63 -> -2064384; A=32767,B=63 -> 2064321; A=-1,B=0 -> 0.
REQ-038 SHALL test ce=0 for 3 cycles with two ops in flight -> outputs frozen; results appear in order after ce=1, op_count=2.
REQ-039 SHALL test reset_n pulse with ops in flight -> res_valid 0, busy 0 immediately; no results after release; rr_ptr=0.
REQ-040 SHALL test 65537 accepted ops -> op_count=1.
